// File: rtl/distortion_sched.sv
// distortion_sched
// Stereo gain/distortion scheduler. Each accepted sample pair is scaled by
// gainNum/gainDen through one shared 16x7 multiplier and one shared restoring
// divider, which serve the left and then the right channel. Each result is then
// clipped to 0.75 or 1.0 of full scale. The result appears 49 clocks after capture.
//
// Optional feature macro: DISTORTION_GAIN_RAMP_EN
//   When defined, the numerator actually used moves one step per accepted
//   sample from its reset value of 0 toward gainNum.
//
// Ports
//   clk                          : single rising-edge clock
//   reset                        : synchronous, active-high reset
//   sampleValid                  : one-cycle strobe marking a new stereo sample
//   leftSampleIn, rightSampleIn  : signed 16-bit input samples
//   gainNum, gainDen             : unsigned 7-bit gain numerator / denominator
//   threshold                    : 1 selects the 0.75 full-scale clip
//   leftSampleOut, rightSampleOut: registered processed samples
//   sampleReady                  : one-cycle pulse when the outputs update
//   busy                         : high whenever a sample is in flight
//   overflow                     : one-cycle pulse when a sampleValid is dropped
module distortion_sched (
  input  logic               clk,
  input  logic               reset,
  input  logic               sampleValid,
  input  logic signed [15:0] leftSampleIn,
  input  logic signed [15:0] rightSampleIn,
  input  logic        [6:0]  gainNum,
  input  logic        [6:0]  gainDen,
  input  logic               threshold,
  output logic signed [15:0] leftSampleOut,
  output logic signed [15:0] rightSampleOut,
  output logic               sampleReady,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic [2:0] {IDLE, MUL_L, DIV_L, MUL_R, DIV_R, CLIP} state_t;

  localparam logic signed [23:0] ClipHiThr  = 24'sd24576;
  localparam logic signed [23:0] ClipLoThr  = -24'sd24577;
  localparam logic signed [23:0] ClipHiFull = 24'sd32767;
  localparam logic signed [23:0] ClipLoFull = -24'sd32768;

  state_t             state_q;
  logic signed [15:0] leftLat_q, rightLat_q;
  logic        [6:0]  numLat_q, denLat_q;
  logic               thrLat_q;
  logic        [22:0] quo_q;
  logic        [6:0]  rem_q;
  logic        [4:0]  bitCnt_q;
  logic               negLat_q, zeroLat_q;
  logic signed [23:0] resL_q, resR_q;
  logic signed [15:0] leftOut_q, rightOut_q;
  logic               ready_q, overflow_q;

  logic               [6:0]  gainSel_d;
  logic signed        [15:0] mulIn_d;
  logic signed        [23:0] product_d;
  logic               [22:0] prodMag_d;
  logic               [7:0]  shifted_d;
  logic                      fits_d;
  logic               [6:0]  diff_d;
  logic               [6:0]  remNext_d;
  logic               [22:0] quoNext_d;
  logic signed        [23:0] divResult_d;

`ifdef DISTORTION_GAIN_RAMP_EN
  logic [6:0] gainEff_q;
  assign gainSel_d = gainEff_q;
`else
  assign gainSel_d = gainNum;
`endif

  // Clamp a 24-bit result into the selected output range.
  function automatic logic signed [15:0] clipSample(input logic signed [23:0] v,
                                                    input logic thr);
    logic signed [23:0] hi, lo, r;
    hi = thr ? ClipHiThr : ClipHiFull;
    lo = thr ? ClipLoThr : ClipLoFull;
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r[15:0];
  endfunction

  // The multiplier and one restoring-divider step are shared by both channels.
  // In MUL_R the multiplier reads the right sample; otherwise it reads the left.
  // When the divisor is zero, the division is skipped and the result saturates
  // in the direction of the product's sign.
  always_comb begin
    mulIn_d     = (state_q == MUL_R) ? rightLat_q : leftLat_q;
    product_d   = $signed({{8{mulIn_d[15]}}, mulIn_d}) * $signed({17'd0, numLat_q});
    prodMag_d   = product_d[23] ? 23'(-product_d) : 23'(product_d);
    shifted_d   = {rem_q, quo_q[22]};
    fits_d      = (shifted_d >= {1'b0, denLat_q});
    diff_d      = 7'(shifted_d - {1'b0, denLat_q});
    remNext_d   = fits_d ? diff_d : shifted_d[6:0];
    quoNext_d   = {quo_q[21:0], fits_d};
    divResult_d = negLat_q ? -$signed({1'b0, quoNext_d}) : $signed({1'b0, quoNext_d});
    if (denLat_q == 7'd0) begin
      if (zeroLat_q)     divResult_d = 24'sd0;
      else if (negLat_q) divResult_d = ClipLoFull;
      else               divResult_d = ClipHiFull;
    end
  end

  // Main sequencer. The dividend is loaded in a MUL state. The divider then runs
  // for 23 quotient bits, most significant bit first; the last step stores the
  // signed channel result. While the FSM is not IDLE, a new sampleValid is dropped
  // and flagged as overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      leftLat_q  <= '0;
      rightLat_q <= '0;
      numLat_q   <= '0;
      denLat_q   <= '0;
      thrLat_q   <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      bitCnt_q   <= '0;
      negLat_q   <= 1'b0;
      zeroLat_q  <= 1'b0;
      resL_q     <= '0;
      resR_q     <= '0;
      leftOut_q  <= '0;
      rightOut_q <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef DISTORTION_GAIN_RAMP_EN
      gainEff_q  <= '0;
`endif
    end else begin
      ready_q    <= 1'b0;
      overflow_q <= sampleValid && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (sampleValid) begin
            leftLat_q  <= leftSampleIn;
            rightLat_q <= rightSampleIn;
            numLat_q   <= gainSel_d;
            denLat_q   <= gainDen;
            thrLat_q   <= threshold;
            state_q    <= MUL_L;
`ifdef DISTORTION_GAIN_RAMP_EN
            if (gainEff_q < gainNum)      gainEff_q <= gainEff_q + 7'd1;
            else if (gainEff_q > gainNum) gainEff_q <= gainEff_q - 7'd1;
`endif
          end
        end
        MUL_L, MUL_R: begin
          quo_q     <= prodMag_d;
          rem_q     <= '0;
          bitCnt_q  <= '0;
          negLat_q  <= product_d < 0;
          zeroLat_q <= product_d == 24'sd0;
          state_q   <= (state_q == MUL_L) ? DIV_L : DIV_R;
        end
        DIV_L, DIV_R: begin
          quo_q    <= quoNext_d;
          rem_q    <= remNext_d;
          bitCnt_q <= bitCnt_q + 5'd1;
          if (bitCnt_q == 5'd22) begin
            if (state_q == DIV_L) begin
              resL_q  <= divResult_d;
              state_q <= MUL_R;
            end else begin
              resR_q  <= divResult_d;
              state_q <= CLIP;
            end
          end
        end
        CLIP: begin
          leftOut_q  <= clipSample(resL_q, thrLat_q);
          rightOut_q <= clipSample(resR_q, thrLat_q);
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign leftSampleOut  = leftOut_q;
  assign rightSampleOut = rightOut_q;
  assign sampleReady    = ready_q;
  assign busy           = (state_q != IDLE);
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_distortion_sched.sv
// tb_distortion_sched
// Directed bench for distortion_sched. Each issued sample pushes its
// hand-computed outputs and its capture cycle into a scoreboard queue. A monitor
// process pops one entry on every sampleReady pulse and checks the output values
// and the 49-cycle latency. Between pulses, the monitor checks that the outputs
// hold steady.
module tb_distortion_sched;

  logic               clk = 1'b0;
  logic               reset;
  logic               sampleValid;
  logic signed [15:0] leftSampleIn, rightSampleIn;
  logic        [6:0]  gainNum, gainDen;
  logic               threshold;
  logic signed [15:0] leftSampleOut, rightSampleOut;
  logic               sampleReady, busy, overflow;

  typedef struct {
    int l;
    int r;
    int cap;
  } exp_t;

  exp_t               sbQ[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 cycCnt = 0;
  int                 readyCount = 0;
  logic signed [15:0] prevL = '0, prevR = '0;

  distortion_sched dut (
    .clk(clk),
    .reset(reset),
    .sampleValid(sampleValid),
    .leftSampleIn(leftSampleIn),
    .rightSampleIn(rightSampleIn),
    .gainNum(gainNum),
    .gainDen(gainDen),
    .threshold(threshold),
    .leftSampleOut(leftSampleOut),
    .rightSampleOut(rightSampleOut),
    .sampleReady(sampleReady),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Edge counter. After capture edge K, this counter reads K.
  always @(posedge clk) cycCnt <= cycCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (sampleReady) begin
        readyCount++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedReady", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("leftOut", int'(leftSampleOut), e.l);
          checkOutput("rightOut", int'(rightSampleOut), e.r);
          checkOutput("latency", cycCnt - e.cap, 49);
        end
      end else begin
        checks++;
        if (leftSampleOut !== prevL || rightSampleOut !== prevR) begin
          errors++;
          $display("[TB] FAIL hold: actual %0d/%0d required %0d/%0d",
                   leftSampleOut, rightSampleOut, prevL, prevR);
        end
      end
    end
    prevL = leftSampleOut;
    prevR = rightSampleOut;
  end

  // Issue one sample and record its expected result. The inputs are scrambled
  // right after capture, so latching errors show up in the outputs.
  task automatic applyStimulus(input int l, input int r, input int num, input int den,
                               input logic thr, input int expL, input int expR);
    @(negedge clk);
    leftSampleIn  = 16'(l);
    rightSampleIn = 16'(r);
    gainNum       = 7'(num);
    gainDen       = 7'(den);
    threshold     = thr;
    sampleValid   = 1'b1;
    sbQ.push_back('{l: expL, r: expR, cap: cycCnt + 1});
    @(negedge clk);
    sampleValid   = 1'b0;
    leftSampleIn  = 16'sh5a5a;
    rightSampleIn = -16'sh1234;
    gainNum       = 7'd99;
    gainDen       = 7'd7;
    threshold     = ~thr;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (sbQ.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainTimeout", sbQ.size(), 0);
    sbQ.delete();
    @(negedge clk);
    checkOutput("busyAfterDrain", int'(busy), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetLeft", int'(leftSampleOut), 0);
    checkOutput("resetRight", int'(rightSampleOut), 0);
    checkOutput("resetReady", int'(sampleReady), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetOverflow", int'(overflow), 0);
    reset = 1'b0;
  endtask

  initial begin
    int rdy0;
    reset         = 1'b1;
    sampleValid   = 1'b0;
    leftSampleIn  = '0;
    rightSampleIn = '0;
    gainNum       = '0;
    gainDen       = '0;
    threshold     = 1'b0;
    doReset();

`ifdef DISTORTION_GAIN_RAMP_EN
    // The ramp starts at 0 and climbs by 1 per sample toward gainNum = 3.
    applyStimulus(100, -100, 3, 1, 1'b0, 0, 0);      waitDrain(80);
    applyStimulus(100, -100, 3, 1, 1'b0, 100, -100); waitDrain(80);
    applyStimulus(100, -100, 3, 1, 1'b0, 200, -200); waitDrain(80);
    applyStimulus(100, -100, 3, 1, 1'b0, 300, -300); waitDrain(80);
`else
    applyStimulus(1000, -1000, 64, 32, 1'b0, 2000, -2000);       waitDrain(80);
    applyStimulus(20000, -20000, 2, 1, 1'b1, 24576, -24577);     waitDrain(80);
    applyStimulus(20000, -20000, 2, 1, 1'b0, 32767, -32768);     waitDrain(80);
    applyStimulus(-7, 7, 1, 2, 1'b0, -3, 3);                     waitDrain(80);
    applyStimulus(5, -5, 1, 0, 1'b0, 32767, -32768);             waitDrain(80);
    applyStimulus(0, 0, 9, 0, 1'b0, 0, 0);                       waitDrain(80);
    applyStimulus(100, -100, 3, 7, 1'b0, 42, -42);               waitDrain(80);
    applyStimulus(-32768, 32767, 127, 127, 1'b0, -32768, 32767); waitDrain(80);
    applyStimulus(-32768, 32767, 127, 127, 1'b1, -24577, 24576); waitDrain(80);
    applyStimulus(123, -456, 0, 5, 1'b0, 0, 0);                  waitDrain(80);

    // A second strobe 10 cycles into a sample is dropped and flagged.
    rdy0 = readyCount;
    applyStimulus(300, -1, 10, 3, 1'b0, 1000, -3);
    repeat (9) @(negedge clk);
    leftSampleIn = 16'sd7777;
    gainNum      = 7'd1;
    gainDen      = 7'd1;
    sampleValid  = 1'b1;
    @(negedge clk);
    sampleValid = 1'b0;
    checkOutput("overflowPulse", int'(overflow), 1);
    checkOutput("busyInFlight", int'(busy), 1);
    @(negedge clk);
    checkOutput("overflowOneCycle", int'(overflow), 0);
    waitDrain(80);
    repeat (60) @(negedge clk);
    checkOutput("singleReady", readyCount - rdy0, 1);

    // Reset 20 cycles after capture aborts the sample. A sampleValid that
    // coincides with reset is ignored.
    @(negedge clk);
    leftSampleIn  = 16'sd1111;
    rightSampleIn = 16'sd2222;
    gainNum       = 7'd1;
    gainDen       = 7'd1;
    sampleValid   = 1'b1;
    @(negedge clk);
    sampleValid = 1'b0;
    repeat (19) @(negedge clk);
    reset       = 1'b1;
    sampleValid = 1'b1;
    @(negedge clk);
    checkOutput("abortLeft", int'(leftSampleOut), 0);
    checkOutput("abortRight", int'(rightSampleOut), 0);
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortReady", int'(sampleReady), 0);
    @(negedge clk);
    checkOutput("resetDominates", int'(busy), 0);
    sampleValid = 1'b0;
    reset       = 1'b0;
    rdy0        = readyCount;
    repeat (60) @(negedge clk);
    checkOutput("noReadyAfterAbort", readyCount - rdy0, 0);
    applyStimulus(1234, -4321, 1, 1, 1'b0, 1234, -4321);         waitDrain(80);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
